fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program-counter / fetch-control stage directly upstream of instruction memory.
//  - Generates current_pc each cycle; instruction memory returns the 9-bit instruction combinationally.
//  - Next-PC sources: sequential (+1), taken branch via an internal branch-target LUT, stall (hold), halt (freeze).
//  - Owns the run/halt state machine, the done flag and a retired-instruction counter.
// PARAMETERS
//  PC_WIDTH     32   width of current_pc
//  TGT_WIDTH    12   width of a LUT branch target; zero-extended to PC_WIDTH
//  LUT_IDX_W    5    LUT index width; 2**LUT_IDX_W entries
//  START_PC     0    PC loaded on every start pulse
//  CNT_WIDTH    16   width of instr_count
// PORTS
//  clk             in   1          rising-edge clock
//  reset           in   1          asynchronous, active-low reset
//  start           in   1          1-cycle pulse; launches execution from IDLE or HALTED
//  stall           in   1          hold PC this cycle (RUN only)
//  branch_taken    in   1          redirect PC to lut[branch_idx] (RUN only)
//  branch_idx      in   LUT_IDX_W  LUT entry selected by the branch
//  halt_req        in   1          executing instruction is HALT; stop after this cycle
//  lut_we          in   1          LUT write enable
//  lut_waddr       in   LUT_IDX_W  LUT write index
//  lut_wdata       in   TGT_WIDTH  LUT write data
//  current_pc      out  PC_WIDTH   PC presented to instruction memory
//  fetch_valid     out  1          1 in RUN: instruction at current_pc is live
//  done            out  1          1 in HALTED
//  instr_count     out  CNT_WIDTH  instructions retired since last start
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, current_pc=START_PC, fetch_valid=0, done=0, instr_count=0,
//    all LUT entries=0. Outputs take reset values immediately, without waiting for clk.
//  - States: IDLE, RUN, HALTED. fetch_valid=(state==RUN); done=(state==HALTED). Both are registered-state decodes.
//  - IDLE:
//    - start=1 -> RUN; current_pc<=START_PC; instr_count<=0.
//    - All other inputs except the LUT write are ignored.
//  - RUN, each edge, priority halt_req > stall > branch_taken > sequential:
//    - halt_req: -> HALTED; current_pc holds; instr_count+1 (the HALT retires).
//    - stall: current_pc and instr_count hold.
//    - branch_taken: current_pc<={zero-ext lut[branch_idx]}; instr_count+1.
//    - else: current_pc<=current_pc+1, modulo 2**PC_WIDTH (all-ones wraps to 0); instr_count+1.
//    - start is ignored while in RUN.
//  - HALTED:
//    - current_pc and instr_count frozen.
//    - start=1 -> RUN with current_pc<=START_PC and instr_count<=0.
//  - instr_count saturates at all-ones; it never wraps.
//  - LUT:
//    - Write takes effect at the edge in any state.
//    - LUT read is combinational on branch_idx.
//    - Same-cycle write and branch to the same index -> the branch uses the OLD value.
//  - Latency: next-PC decision is 1 cycle (inputs sampled at edge N, current_pc valid after edge N).
//  - Reset asserted mid-RUN: immediate return to IDLE state and values; a pending start is lost.
// STRUCTURE
//  - Package fetch_pkg: state_t enum {IDLE,RUN,HALTED}; default widths as localparams.
//  - Sub-module branch_target_lut: 2**LUT_IDX_W x TGT_WIDTH register file.
//    - 1 async-read port, 1 sync-write port.
//    - Async active-low clear.
//  - Top level holds the FSM, PC register and counter.
// TESTING
//  1. Reset low mid-cycle -> current_pc=0, fetch_valid=0, done=0 before the next edge.
//     After release, no start -> pc stays 0 for 10 cycles.
//  2. start, 5 free cycles -> pc 0,1,2,3,4,5; instr_count=5.
//  3. lut[3]=0x0A5; branch_taken, idx=3 at pc=7 -> next pc=0x0A5.
//     Same-edge write lut[3]=0x011 with branch idx=3 -> pc=0x0A5; a later branch -> 0x011.
//  4. stall 3 cycles at pc=4 -> pc and count hold.
//     stall+branch_taken together -> stall wins, pc stays 4.
//  5. halt_req at pc=9 -> done=1, pc=9 frozen, count includes the halt.
//     start -> pc=0, count=0, done=0.
//  6. Force pc=32'hFFFF_FFFF, run one cycle -> pc=0.
//     Preload count near max -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: the run/halt state encoding and the
// default widths used by fetch_unit and branch_target_lut.
package fetch_pkg;

  localparam int unsigned DEF_PC_WIDTH  = 32;
  localparam int unsigned DEF_TGT_WIDTH = 12;
  localparam int unsigned DEF_LUT_IDX_W = 5;
  localparam int unsigned DEF_CNT_WIDTH = 16;
  localparam int unsigned DEF_START_PC  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/branch_target_lut.sv
// Branch-target register file: 2**IDX_W entries of TGT_WIDTH bits.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low clear (all entries -> 0)
//   we, waddr, wdata  synchronous write port
//   raddr, rdata      combinational read port; a same-edge write is not visible
//                     until after the edge, so a concurrent read sees the old value
module branch_target_lut
  import fetch_pkg::*;
#(
  parameter int unsigned IDX_W     = DEF_LUT_IDX_W,
  parameter int unsigned TGT_WIDTH = DEF_TGT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [TGT_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]     raddr,
  output logic [TGT_WIDTH-1:0] rdata
);

  localparam int unsigned Entries = 2 ** IDX_W;

  logic [TGT_WIDTH-1:0] mem_q [Entries];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Entries; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Program-counter / fetch-control stage feeding instruction memory.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   start                 pulse: (re)launch from IDLE or HALTED at START_PC
//   stall                 hold PC and count (RUN only)
//   branch_taken/_idx     redirect PC to lut[branch_idx] (RUN only)
//   halt_req              current instruction is HALT; retire it and stop
//   lut_we/_waddr/_wdata  branch-target LUT write, honoured in any state
//   current_pc            PC presented to instruction memory
//   fetch_valid           state is RUN
//   done                  state is HALTED
//   instr_count           saturating count of instructions retired since start
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned            PC_WIDTH  = DEF_PC_WIDTH,
  parameter int unsigned            TGT_WIDTH = DEF_TGT_WIDTH,
  parameter int unsigned            LUT_IDX_W = DEF_LUT_IDX_W,
  parameter logic [PC_WIDTH-1:0]    START_PC  = PC_WIDTH'(DEF_START_PC),
  parameter int unsigned            CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic                 halt_req,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [TGT_WIDTH-1:0] lut_wdata,
  output logic [PC_WIDTH-1:0]  current_pc,
  output logic                 fetch_valid,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [PC_WIDTH-1:0]  PcOne  = PC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [TGT_WIDTH-1:0] lut_rdata;

  branch_target_lut #(
    .IDX_W     (LUT_IDX_W),
    .TGT_WIDTH (TGT_WIDTH)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (branch_idx),
    .rdata (lut_rdata)
  );

  // Saturate rather than wrap so a long run never reports a small count.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_d = HALTED;
          cnt_d   = cnt_inc;
        end else if (stall) begin
          // hold PC and count
        end else if (branch_taken) begin
          pc_d  = PC_WIDTH'(lut_rdata);
          cnt_d = cnt_inc;
        end else begin
          pc_d  = pc_q + PcOne;
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign current_pc  = pc_q;
  assign fetch_valid = (state_q == RUN);
  assign done        = (state_q == HALTED);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Two instances share one stimulus stream: "a" uses the default widths, "b" a
// 12-bit PC, 4-bit counter and START_PC=3 so PC wrap and counter saturation are
// reachable in a few cycles.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start, stall, branch_taken, halt_req, lut_we;
  logic [4:0]  branch_idx, lut_waddr;
  logic [11:0] lut_wdata;

  logic [31:0] pc_a;
  logic        fv_a, done_a;
  logic [15:0] cnt_a;
  logic [11:0] pc_b;
  logic        fv_b, done_b;
  logic [3:0]  cnt_b;

  int ntests = 0;
  int nfail  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fetch_unit u_a (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_idx   (branch_idx),
    .halt_req     (halt_req),
    .lut_we       (lut_we),
    .lut_waddr    (lut_waddr),
    .lut_wdata    (lut_wdata),
    .current_pc   (pc_a),
    .fetch_valid  (fv_a),
    .done         (done_a),
    .instr_count  (cnt_a)
  );

  fetch_unit #(
    .PC_WIDTH  (12),
    .TGT_WIDTH (12),
    .LUT_IDX_W (5),
    .START_PC  (12'd3),
    .CNT_WIDTH (4)
  ) u_b (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_idx   (branch_idx),
    .halt_req     (halt_req),
    .lut_we       (lut_we),
    .lut_waddr    (lut_waddr),
    .lut_wdata    (lut_wdata),
    .current_pc   (pc_b),
    .fetch_valid  (fv_b),
    .done         (done_b),
    .instr_count  (cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 halted
  int          m_mode [2];
  logic [31:0] m_pc   [2];
  int          m_cnt  [2];
  logic [11:0] m_lut  [32];

  function automatic logic [31:0] pc_mask(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_0FFF;
  endfunction

  function automatic int cnt_max(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  function automatic logic [31:0] start_pc(input int k);
    return (k == 0) ? 32'd0 : 32'd3;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = 0;
        m_pc[k]   = start_pc(k);
        m_cnt[k]  = 0;
      end
      for (int i = 0; i < 32; i++) m_lut[i] = 12'h0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_mode[k] == 1) begin
          if (halt_req) begin
            m_mode[k] = 2;
            if (m_cnt[k] < cnt_max(k)) m_cnt[k] = m_cnt[k] + 1;
          end else if (!stall) begin
            if (branch_taken) m_pc[k] = {20'h0, m_lut[branch_idx]} & pc_mask(k);
            else              m_pc[k] = (m_pc[k] + 32'd1) & pc_mask(k);
            if (m_cnt[k] < cnt_max(k)) m_cnt[k] = m_cnt[k] + 1;
          end
        end else if (start) begin
          m_mode[k] = 1;
          m_pc[k]   = start_pc(k);
          m_cnt[k]  = 0;
        end
      end
      // write after the branch read: a same-edge branch sees the old entry
      if (lut_we) m_lut[lut_waddr] = lut_wdata;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_a",   pc_a,            m_pc[0]);
      check("fv_a",   32'(fv_a),       32'(m_mode[0] == 1));
      check("done_a", 32'(done_a),     32'(m_mode[0] == 2));
      check("cnt_a",  32'(cnt_a),      32'(m_cnt[0]));
      check("pc_b",   {20'h0, pc_b},   m_pc[1]);
      check("fv_b",   32'(fv_b),       32'(m_mode[1] == 1));
      check("done_b", 32'(done_b),     32'(m_mode[1] == 2));
      check("cnt_b",  32'(cnt_b),      32'(m_cnt[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic s, input logic st, input logic br, input logic [4:0] idx,
                       input logic h, input logic we, input logic [4:0] wa,
                       input logic [11:0] wd);
    start = s; stall = st; branch_taken = br; branch_idx = idx; halt_req = h;
    lut_we = we; lut_waddr = wa; lut_wdata = wd;
    @(negedge clk);
    start = 0; stall = 0; branch_taken = 0; branch_idx = 0; halt_req = 0;
    lut_we = 0; lut_waddr = 0; lut_wdata = 0;
  endtask

  task automatic free_cyc(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    start = 0; stall = 0; branch_taken = 0; branch_idx = 0; halt_req = 0;
    lut_we = 0; lut_waddr = 0; lut_wdata = 0;

    // 1. reset mid-cycle takes effect before any edge
    #2 reset = 1'b0;
    #1;
    check("rst_pc",   pc_a,          32'h0);
    check("rst_fv",   32'(fv_a),     32'h0);
    check("rst_done", 32'(done_a),   32'h0);
    check("rst_cnt",  32'(cnt_a),    32'h0);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    // IDLE ignores everything but a LUT write
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'(i), 1'(i >> 1), 5'(i), 1'(i >> 2), 1'(i == 4), 5'd2, 12'h123);
    end
    check("idle_pc", pc_a,      32'h0);
    check("idle_fv", 32'(fv_a), 32'h0);

    // 2. start then five sequential fetches
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("start_pc", pc_a,      32'h0);
    check("start_fv", 32'(fv_a), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      free_cyc(1);
      check("seq_pc", pc_a, 32'(i));
    end
    check("seq_cnt", 32'(cnt_a), 32'd5);

    // 3. branches through the LUT, same-edge write sees old value
    drive(0, 0, 0, 0, 0, 1, 5'd3, 12'h0A5);          // pc 6
    free_cyc(1);                                      // pc 7
    drive(0, 0, 1, 5'd3, 0, 0, 0, 0);
    check("br_pc", pc_a, 32'h0A5);
    drive(0, 0, 1, 5'd3, 0, 1, 5'd3, 12'h011);
    check("br_old", pc_a, 32'h0A5);
    drive(0, 0, 1, 5'd3, 0, 0, 0, 0);
    check("br_new", pc_a, 32'h011);
    drive(0, 0, 1, 5'd2, 0, 0, 0, 0);
    check("br_idlewr", pc_a, 32'h123);
    check("br_cnt", 32'(cnt_a), 32'd11);

    // 4. stall holds; stall beats branch
    drive(0, 0, 0, 0, 0, 1, 5'd1, 12'h004);          // pc 0x124
    drive(0, 0, 1, 5'd1, 0, 0, 0, 0);                // pc 4, cnt 13
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 0, 0);
    check("stall_pc",  pc_a,       32'd4);
    check("stall_cnt", 32'(cnt_a), 32'd13);
    drive(0, 1, 1, 5'd3, 0, 0, 0, 0);
    check("stallbr_pc", pc_a, 32'd4);

    // start in RUN is ignored: plain sequential step
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("run_start_pc",  pc_a,       32'd5);
    check("run_start_cnt", 32'(cnt_a), 32'd14);

    // 5. halt at pc 9
    free_cyc(4);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    check("halt_done", 32'(done_a), 32'h1);
    check("halt_fv",   32'(fv_a),   32'h0);
    check("halt_pc",   pc_a,        32'd9);
    check("halt_cnt",  32'(cnt_a),  32'd19);
    check("sat_cnt_b", 32'(cnt_b),  32'hF);
    drive(0, 1, 1, 5'd3, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("frozen_pc",  pc_a,       32'd9);
    check("frozen_cnt", 32'(cnt_a), 32'd19);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("restart_pc",   pc_a,        32'h0);
    check("restart_cnt",  32'(cnt_a),  32'h0);
    check("restart_done", 32'(done_a), 32'h0);
    check("restart_pc_b", {20'h0, pc_b}, 32'd3);

    // 6. wrap: branch to 0xFFF then step; 12-bit PC wraps, 32-bit does not
    drive(0, 0, 0, 0, 0, 1, 5'd7, 12'hFFF);
    drive(0, 0, 1, 5'd7, 0, 0, 0, 0);
    check("tgt_pc", pc_a, 32'hFFF);
    free_cyc(1);
    check("wrap_pc_a", pc_a,           32'h1000);
    check("wrap_pc_b", {20'h0, pc_b},  32'h0);

    // reset mid-RUN: immediate return; a start seen under reset is lost
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_pc",   pc_a,          32'h0);
    check("mid_rst_fv",   32'(fv_a),     32'h0);
    check("mid_rst_cnt",  32'(cnt_a),    32'h0);
    check("mid_rst_pc_b", {20'h0, pc_b}, 32'd3);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    free_cyc(2);
    check("lost_start_fv", 32'(fv_a), 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 5'd3, 0, 0, 0, 0);
    check("lut_cleared", pc_a,       32'h0);
    check("post_cnt",    32'(cnt_a), 32'd1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
